// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding program-memory
// reads, buffers words in a prefetch FIFO and handles jump/interrupt redirects and lock.
module inst_fetch_unit #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DATA_W     = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              n_rst,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_req,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_ack,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [ADDR_W-1:0] o_head_pc,
  input  logic              i_pc_set,
  input  logic [ADDR_W-1:0] i_pc_target,
  input  logic              i_interrupt,
  input  logic [ADDR_W-1:0] i_int_vector,
  output logic [ADDR_W-1:0] o_ret_pc,
  input  logic              i_lock
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                run_q;
  logic [ADDR_W-1:0]   fpc_q, fpc_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   ret_pc_q, ret_pc_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                redirect_s, issue_s, req_s, ack_s, push_s, pop_s, valid_s;
  logic [ADDR_W-1:0]   target_s;

  // run_q keeps the request low in the first cycle after reset so a stale ack is ignored
  assign redirect_s = i_interrupt | i_pc_set;
  assign target_s   = i_interrupt ? i_int_vector : i_pc_target;
  assign issue_s    = run_q && (state_q == S_IDLE) && !i_lock && (count_q < DEPTH_C) && !redirect_s;
  assign req_s      = issue_s || (state_q != S_IDLE);
  assign ack_s      = req_s && i_mem_ack;
  assign push_s     = ack_s && (state_q != S_DISCARD) && !redirect_s;
  assign valid_s    = (count_q != {CNT_W{1'b0}}) && !i_lock && !redirect_s;
  assign pop_s      = valid_s && i_word_ready;

  assign o_mem_req    = req_s;
  assign o_mem_addr   = (state_q == S_IDLE) ? fpc_q : addr_q;
  assign o_word_valid = valid_s;
  assign o_word       = (count_q != {CNT_W{1'b0}}) ? fifo_q[rd_ptr_q] : last_q;
  assign o_head_pc    = head_pc_q;
  assign o_ret_pc     = ret_pc_q;

  // next-state for the FSM, PCs and FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    head_pc_d = head_pc_q;
    addr_d    = addr_q;
    ret_pc_d  = ret_pc_q;
    last_d    = last_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    case (state_q)
      S_IDLE: begin
        if (issue_s && !i_mem_ack) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ack_s) begin
          state_d = S_IDLE;
        end else if (redirect_s) begin
          state_d = S_DISCARD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DISCARD: begin
        if (ack_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DISCARD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue_s) begin
      addr_d = fpc_q;
    end else begin
      addr_d = addr_q;
    end

    if (redirect_s) begin
      fpc_d     = target_s;
      head_pc_d = target_s;
      count_d   = {CNT_W{1'b0}};
      wr_ptr_d  = {PTR_W{1'b0}};
      rd_ptr_d  = {PTR_W{1'b0}};
      if (count_q != {CNT_W{1'b0}}) begin
        last_d = fifo_q[rd_ptr_q];
      end else begin
        last_d = last_q;
      end
    end else begin
      if (push_s) begin
        fpc_d    = fpc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        fpc_d    = fpc_q;
      end
      if (pop_s) begin
        head_pc_d = head_pc_q + ADDR_W'(1);
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        last_d    = fifo_q[rd_ptr_q];
      end else begin
        head_pc_d = head_pc_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    if (i_interrupt) begin
      ret_pc_d = head_pc_q;
    end else begin
      ret_pc_d = ret_pc_q;
    end
  end

  // state and control registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      fpc_q     <= RESET_PC;
      head_pc_q <= RESET_PC;
      addr_q    <= RESET_PC;
      ret_pc_q  <= {ADDR_W{1'b0}};
      last_q    <= {DATA_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      fpc_q     <= fpc_d;
      head_pc_q <= head_pc_d;
      addr_q    <= addr_d;
      ret_pc_q  <= ret_pc_d;
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // storage array; only occupied entries are ever read
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= i_mem_data;
    end
  end

endmodule
